// File: rtl/icache_pkg.sv
`timescale 1ns/1ps
// Shared geometry, FSM state encoding and address-split helpers for the instruction cache.
// No logic and no latency of its own. Only constants and pure functions.
// No flow control of its own. Users handle their own stalls.
package icache_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:INDEX_W+OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_direct_map_if.sv
`timescale 1ns/1ps
// Fetch-side and instruction-memory-side signal bundle for the instruction cache.
// Wires only, so it adds no latency.
// Backpressure is the ic_stall flag. The memory side has a fixed latency and cannot be stalled.
interface icache_direct_map_if;
  import icache_pkg::*;

  logic [ADDR_W-1:0] pc_addr;
  logic              pc_req;
  logic              inv_all;
  logic [DATA_W-1:0] ic_instr;
  logic              ic_stall;
  logic [ADDR_W-1:0] IM_Address;
  logic              IM_en_Read;
  logic [DATA_W-1:0] Instruction;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  // Fetch stage and instruction memory side
  modport master (
    output pc_addr, pc_req, inv_all, Instruction,
    input  ic_instr, ic_stall, IM_Address, IM_en_Read, hit_cnt, miss_cnt
  );

  // Cache side
  modport slave (
    input  pc_addr, pc_req, inv_all, Instruction,
    output ic_instr, ic_stall, IM_Address, IM_en_Read, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/icache_line_array.sv
`timescale 1ns/1ps
// Valid, tag and data storage for the direct-mapped lines.
// Reads are combinational. Writes and invalidates take effect at the clock edge.
// No backpressure. The caller issues at most one write per cycle.
module icache_line_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inv_all,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  // Valid bits: invalidate-all beats a fill landing in the same cycle
  always_comb begin
    valid_d = valid_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  // Tag and data: write the filled line and leave the others unchanged
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (wr_en) begin
      tag_d[wr_idx]  = wr_tag;
      data_d[wr_idx] = wr_data;
    end
  end

  // Valid bits are the only state that must clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data payload are only trusted behind a set valid bit
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct_map.sv
`timescale 1ns/1ps
// Direct-mapped read-only instruction cache. One word per line. Optional hit/miss counters under ICACHE_PERF_EN.
// A hit returns the word in the same cycle. A miss stalls for MEM_LAT+2 cycles, then the re-lookup hits.
// ic_stall holds fetch during a refill. Memory reads are fire-and-forget with a fixed latency.
module icache_direct_map
  import icache_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  icache_direct_map_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               im_en_q, im_en_d;
  logic               fill_en;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               lookup_hit;

  icache_line_array u_lines (
    .clk      (clk),
    .rst      (rst),
    .inv_all  (bus.inv_all),
    .wr_en    (fill_en),
    .wr_idx   (get_index(miss_addr_q)),
    .wr_tag   (get_tag(miss_addr_q)),
    .wr_data  (bus.Instruction),
    .rd_idx   (get_index(bus.pc_addr)),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // Lookup is only meaningful in IDLE. REQ and WAIT always stall.
  always_comb begin
    lookup_hit = (state_q == IDLE) && bus.pc_req && rd_valid &&
                 (rd_tag == get_tag(bus.pc_addr));
  end

  // Miss FSM next state: latch the miss, strobe memory once, count down, then fill
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    cnt_d       = cnt_q;
    im_en_d     = 1'b0;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pc_req && !lookup_hit) begin
          state_d     = REQ;
          miss_addr_d = align_addr(bus.pc_addr);
          im_en_d     = 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, miss address, latency counter and registered read strobe.
  // Reset aborts any refill in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      cnt_q       <= '0;
      im_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      cnt_q       <= cnt_d;
      im_en_q     <= im_en_d;
    end
  end

  // Fetch-facing outputs. Reset forces a quiet NOP/no-stall even if fetch is requesting.
  always_comb begin
    bus.ic_stall   = !rst && ((state_q != IDLE) || (bus.pc_req && !lookup_hit));
    bus.ic_instr   = lookup_hit ? rd_data : '0;
    bus.IM_Address = miss_addr_q;
    bus.IM_en_Read = im_en_q;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // One hit per serviced IDLE lookup, one miss per refill launched
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(lookup_hit);
    miss_cnt_d = miss_cnt_q + 32'((state_q == IDLE) && (state_d == REQ));
  end

  // Free-running performance counters, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

endmodule
